// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : Row-scan scheduler for the LED matrix output path. Requests
//               the column shift of row r+1 while row r is displayed, then
//               runs blank -> latch -> row address update -> GCLK burst.
//               Framebuffer swaps are applied only on the row-0 shift so a
//               frame never tears.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl #(
    parameter int LED_ROWS     = 4,
    parameter int GCLK_PULSES  = 256,
    parameter int GCLK_DIV     = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int LE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       swap_req_i,
    input  logic       shift_done_i,
    output logic       shift_start_o,
    output logic [3:0] shift_row_o,
    output logic       buf_sel_o,
    output logic       swap_ack_o,
    output logic       frame_start_o,
    output logic       le_o,
    output logic       gclk_o,
    output logic       blank_o,
    output logic [3:0] row_addr_o
);

    localparam int c_PULSE_W = $clog2(GCLK_PULSES + 1);
    localparam int c_DIV_W   = (GCLK_DIV > 1) ? $clog2(GCLK_DIV) : 1;
    localparam int c_PH_MAX  = (BLANK_CYCLES > LE_CYCLES) ? BLANK_CYCLES : LE_CYCLES;
    localparam int c_PH_W    = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    localparam logic [3:0]           c_LAST_ROW   = 4'(LED_ROWS - 1);
    localparam logic [c_PULSE_W-1:0] c_PULSES     = c_PULSE_W'(GCLK_PULSES);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(GCLK_DIV - 1);
    localparam logic [c_PH_W-1:0]    c_BLANK_LAST = c_PH_W'(BLANK_CYCLES - 1);
    localparam logic [c_PH_W-1:0]    c_LE_LAST    = c_PH_W'(LE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    state_t               state_q;
    logic                 shift_start_q;
    logic [3:0]           shift_row_q;
    logic                 buf_sel_q;
    logic                 swap_ack_q;
    logic                 frame_start_q;
    logic                 le_q;
    logic                 gclk_q;
    logic                 blank_q;
    logic [3:0]           row_addr_q;
    logic                 swap_pend_q;   // swap requested, waiting for next row-0 shift
    logic                 armed_q;       // shift outstanding, first shift_done accepted
    logic                 done_q;        // sticky: outstanding shift has completed
    logic [c_PH_W-1:0]    ph_cnt_q;      // cycles spent in BLANK / LATCH
    logic [c_DIV_W-1:0]   div_cnt_q;     // cycles within current GCLK half-period
    logic [c_PULSE_W-1:0] pulse_cnt_q;   // GCLK falling edges in this row

    logic [3:0] next_row_d;
    logic       done_d;
    logic       swap_now_d;

    // Row to prefetch while the current row is on display; wraps to 0.
    assign next_row_d = (row_addr_q == c_LAST_ROW) ? 4'd0 : row_addr_q + 4'd1;
    // Shift completion including a shift_done arriving this very cycle.
    assign done_d     = done_q | (armed_q & shift_done_i);
    // A swap_req coincident with the row-0 shift is honoured immediately.
    assign swap_now_d = swap_pend_q | swap_req_i;

    // Scan sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shift_start_q <= 1'b0;
            shift_row_q   <= 4'd0;
            buf_sel_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            le_q          <= 1'b0;
            gclk_q        <= 1'b0;
            blank_q       <= 1'b1;
            row_addr_q    <= 4'd0;
            swap_pend_q   <= 1'b0;
            armed_q       <= 1'b0;
            done_q        <= 1'b0;
            ph_cnt_q      <= '0;
            div_cnt_q     <= '0;
            pulse_cnt_q   <= '0;
        end else begin
            shift_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;

            // Only the first shift_done after a request counts; the window
            // opens the cycle after the shift_start pulse.
            if (shift_start_q) begin
                armed_q <= 1'b1;
            end else if (armed_q && shift_done_i) begin
                armed_q <= 1'b0;
                done_q  <= 1'b1;
            end

            if (swap_req_i) begin
                swap_pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    blank_q <= 1'b1;
                    le_q    <= 1'b0;
                    gclk_q  <= 1'b0;
                    if (enable_i) begin
                        shift_start_q <= 1'b1;
                        shift_row_q   <= 4'd0;
                        frame_start_q <= 1'b1;
                        armed_q       <= 1'b0;
                        done_q        <= 1'b0;
                        if (swap_now_d) begin
                            buf_sel_q   <= ~buf_sel_q;
                            swap_ack_q  <= 1'b1;
                            swap_pend_q <= 1'b0;
                        end
                        state_q <= ST_PRIME;
                    end
                end

                ST_PRIME: begin
                    if (done_d) begin
                        ph_cnt_q <= '0;
                        state_q  <= ST_BLANK;
                    end
                end

                ST_BLANK: begin
                    if (ph_cnt_q == c_BLANK_LAST) begin
                        ph_cnt_q   <= '0;
                        le_q       <= 1'b1;
                        row_addr_q <= shift_row_q;
                        state_q    <= ST_LATCH;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + c_PH_W'(1);
                    end
                end

                ST_LATCH: begin
                    if (ph_cnt_q == c_LE_LAST) begin
                        le_q          <= 1'b0;
                        blank_q       <= 1'b0;
                        gclk_q        <= 1'b1;
                        div_cnt_q     <= '0;
                        pulse_cnt_q   <= '0;
                        shift_start_q <= 1'b1;
                        shift_row_q   <= next_row_d;
                        armed_q       <= 1'b0;
                        done_q        <= 1'b0;
                        if (next_row_d == 4'd0) begin
                            frame_start_q <= 1'b1;
                            if (swap_now_d) begin
                                buf_sel_q   <= ~buf_sel_q;
                                swap_ack_q  <= 1'b1;
                                swap_pend_q <= 1'b0;
                            end
                        end
                        state_q <= ST_DISPLAY;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + c_PH_W'(1);
                    end
                end

                ST_DISPLAY: begin
                    if (pulse_cnt_q != c_PULSES) begin
                        if (div_cnt_q == c_DIV_LAST) begin
                            div_cnt_q <= '0;
                            gclk_q    <= ~gclk_q;
                            if (gclk_q) begin
                                pulse_cnt_q <= pulse_cnt_q + c_PULSE_W'(1);
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + c_DIV_W'(1);
                        end
                    end else if (done_d) begin
                        // Burst complete and next row shifted: leave with GCLK low.
                        gclk_q  <= 1'b0;
                        blank_q <= 1'b1;
                        if (enable_i) begin
                            ph_cnt_q <= '0;
                            state_q  <= ST_BLANK;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_start_o = shift_start_q;
    assign shift_row_o   = shift_row_q;
    assign buf_sel_o     = buf_sel_q;
    assign swap_ack_o    = swap_ack_q;
    assign frame_start_o = frame_start_q;
    assign le_o          = le_q;
    assign gclk_o        = gclk_q;
    assign blank_o       = blank_q;
    assign row_addr_o    = row_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_ctrl
// Description : Scoreboard bench for matrix_scan_ctrl. Stimulus queues the
//               expected shift requests and latched rows; a monitor pops and
//               compares them whenever the DUT pulses shift_start or le, and
//               checks GCLK burst shape and blank/latch timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    localparam int ROWS   = 4;
    localparam int PULSES = 8;
    localparam int DIV    = 1;
    localparam int BLANKC = 2;
    localparam int LEC    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       swap_req = 1'b0;
    logic       model_done = 1'b0;
    logic       stray_done = 1'b0;
    logic       shift_done;
    logic       shift_start_o;
    logic [3:0] shift_row_o;
    logic       buf_sel_o;
    logic       swap_ack_o;
    logic       frame_start_o;
    logic       le_o;
    logic       gclk_o;
    logic       blank_o;
    logic [3:0] row_addr_o;

    assign shift_done = model_done | stray_done;

    matrix_scan_ctrl #(
        .LED_ROWS    (ROWS),
        .GCLK_PULSES (PULSES),
        .GCLK_DIV    (DIV),
        .BLANK_CYCLES(BLANKC),
        .LE_CYCLES   (LEC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .swap_req_i   (swap_req),
        .shift_done_i (shift_done),
        .shift_start_o(shift_start_o),
        .shift_row_o  (shift_row_o),
        .buf_sel_o    (buf_sel_o),
        .swap_ack_o   (swap_ack_o),
        .frame_start_o(frame_start_o),
        .le_o         (le_o),
        .gclk_o       (gclk_o),
        .blank_o      (blank_o),
        .row_addr_o   (row_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0] row;
        logic       bsel;
        logic       frame;
        logic       ack;
    } start_t;

    start_t     start_q[$];
    logic [3:0] le_q[$];
    start_t     exp_s;

    int checks = 0;
    int errors = 0;
    int le_count = 0;
    int start_count = 0;
    int shifter_delay = 10;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_start(input int row, input int bsel, input int frame, input int ack);
        start_t s;
        s.row   = 4'(row);
        s.bsel  = 1'(bsel);
        s.frame = 1'(frame);
        s.ack   = 1'(ack);
        start_q.push_back(s);
    endtask

    // Shifter model: answers each shift_start after shifter_delay cycles.
    int model_d;
    bit model_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && shift_start_o) begin
                model_d     = shifter_delay;
                model_abort = 1'b0;
                for (int i = 0; i < model_d; i++) begin
                    @(posedge clk);
                    if (!rst_n) begin
                        model_abort = 1'b1;
                        break;
                    end
                end
                if (!model_abort) begin
                    #1 model_done = 1'b1;
                    @(posedge clk);
                    #1 model_done = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard
    logic blank_p = 1'b1;
    logic le_p = 1'b0;
    logic gclk_p = 1'b0;
    int   falls = 0, hi_run = 0, lo_run = 0, le_run = 0, blank_run = 0;
    int   disp_start = 0, done_cyc = 0, exp_len = 0;
    bit   after_disp = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            blank_p = 1'b1; le_p = 1'b0; gclk_p = 1'b0;
            falls = 0; hi_run = 0; lo_run = 0; le_run = 0; blank_run = 0;
            after_disp = 1'b0;
        end else begin
            if (model_done) done_cyc = cyc;

            if (shift_start_o) begin
                start_count++;
                if (blank_o) after_disp = 1'b0;
                if (start_q.size() == 0) begin
                    chk("unexpected_shift_start", 1, 0);
                end else begin
                    exp_s = start_q.pop_front();
                    chk("shift_row",   int'(shift_row_o),   int'(exp_s.row));
                    chk("buf_sel",     int'(buf_sel_o),     int'(exp_s.bsel));
                    chk("frame_start", int'(frame_start_o), int'(exp_s.frame));
                    chk("swap_ack",    int'(swap_ack_o),    int'(exp_s.ack));
                end
            end else begin
                if (frame_start_o) chk("stray_frame_start", 1, 0);
                if (swap_ack_o)    chk("stray_swap_ack", 1, 0);
            end

            if (le_o && (gclk_o || !blank_o)) chk("le_overlap", 1, 0);
            if (gclk_o && blank_o)            chk("gclk_while_blank", 1, 0);

            if (le_o && !le_p) begin
                le_count++;
                if (le_q.size() == 0) chk("unexpected_le", 1, 0);
                else                  chk("row_addr", int'(row_addr_o), int'(le_q.pop_front()));
                if (after_disp) chk("blank_cycles", blank_run, BLANKC);
                else            chk("done_to_le", cyc, done_cyc + 1 + BLANKC);
            end
            if (le_o) le_run = le_p ? le_run + 1 : 1;
            if (!le_o && le_p) chk("le_cycles", le_run, LEC);

            if (!blank_o && blank_p) begin
                chk("le_before_display", int'(le_p), 1);
                disp_start = cyc;
                falls = 0; hi_run = 0; lo_run = 0;
            end

            if (!blank_o) begin
                if (gclk_p && !gclk_o) begin
                    falls++;
                    chk("gclk_high_len", hi_run, DIV);
                end
                if (!gclk_p && gclk_o) begin
                    if (falls >= PULSES) chk("gclk_rise_after_burst", 1, 0);
                    if (falls > 0)       chk("gclk_low_len", lo_run, DIV);
                end
                hi_run = gclk_o ? (gclk_p ? hi_run + 1 : 1) : 0;
                lo_run = !gclk_o ? (!gclk_p ? lo_run + 1 : 1) : 0;
            end

            if (blank_o && !blank_p) begin
                after_disp = 1'b1;
                chk("gclk_pulses", falls, PULSES);
                exp_len = disp_start + 2 * PULSES * DIV;
                if (done_cyc + 1 > exp_len) exp_len = done_cyc + 1;
                chk("display_exit_cycle", cyc, exp_len);
            end

            blank_run = (blank_o && !le_o) ? blank_run + 1 : 0;
            blank_p = blank_o; le_p = le_o; gclk_p = gclk_o;
        end
    end

    // Wait for le_count==n plus a condition: mode 0 none, 1 display, 2 le high.
    task automatic wait_cond(input int mode, input int n, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (le_count == n && (mode == 0 || (mode == 1 && !blank_o) || (mode == 2 && le_o))) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({"timeout_", name}, le_count, n);
    endtask

    task automatic pulse_swap();
        @(posedge clk); #1 swap_req = 1'b1;
        @(posedge clk); #1 swap_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blank", int'(blank_o), 1);
        chk("rst_le", int'(le_o), 0);
        chk("rst_gclk", int'(gclk_o), 0);
        chk("rst_shift_start", int'(shift_start_o), 0);
        chk("rst_row_addr", int'(row_addr_o), 0);
        chk("rst_buf_sel", int'(buf_sel_o), 0);
        chk("rst_frame_start", int'(frame_start_o), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_no_start", start_count, 0);

        // Free-run: swap merged at start 16, coincident swap at start 20,
        // slow shifter on start 22, enable dropped during latch 24.
        for (int k = 0; k < 26; k++)
            push_start(k % ROWS, (k >= 16 && k < 20) ? 1 : 0, (k % ROWS == 0) ? 1 : 0,
                       (k == 16 || k == 20) ? 1 : 0);
        for (int k = 0; k < 25; k++) le_q.push_back(4'(k % ROWS));
        @(posedge clk); #1 enable = 1'b1;

        wait_cond(1, 15, "row2_display");
        repeat (3) pulse_swap();

        wait_cond(2, 20, "row3_latch");
        swap_req = 1'b1;
        @(posedge clk); #1 swap_req = 1'b0;

        wait_cond(1, 21, "slow_setup");
        shifter_delay = 40;
        wait_cond(1, 22, "slow_restore");
        shifter_delay = 10;

        wait_cond(1, 25, "disable_row");
        enable = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("idle_le_count", le_count, 25);
        chk("idle_start_count", start_count, 26);
        chk("idle_blank", int'(blank_o), 1);
        chk("idle_gclk", int'(gclk_o), 0);
        repeat (3) begin
            @(posedge clk); #1 stray_done = 1'b1;
            @(posedge clk); #1 stray_done = 1'b0;
            repeat (3) @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
        chk("stray_start_count", start_count, 26);
        chk("stray_le_count", le_count, 25);
        chk("stray_blank", int'(blank_o), 1);
        chk("idle_row_addr_kept", int'(row_addr_o), 0);

        // Swap requested while idle, applied on the restart.
        pulse_swap();
        push_start(0, 1, 1, 1);
        push_start(1, 1, 0, 0);
        push_start(2, 1, 0, 0);
        le_q.push_back(4'd0);
        le_q.push_back(4'd1);
        @(posedge clk); #1 enable = 1'b1;

        // Asynchronous reset mid-display with gclk high.
        wait_cond(1, 27, "row1_display");
        repeat (4) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (gclk_o) begin
                found = 1'b1;
                break;
            end
        end
        chk("pre_reset_gclk_high", int'(found), 1);
        chk("pre_reset_row_addr", int'(row_addr_o), 1);
        chk("pre_reset_buf_sel", int'(buf_sel_o), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_gclk", int'(gclk_o), 0);
        chk("async_rst_blank", int'(blank_o), 1);
        chk("async_rst_row_addr", int'(row_addr_o), 0);
        chk("async_rst_buf_sel", int'(buf_sel_o), 0);
        chk("async_rst_le", int'(le_o), 0);
        chk("pending_starts", start_q.size(), 0);
        chk("pending_latches", le_q.size(), 0);
        push_start(0, 0, 1, 0);
        push_start(1, 0, 0, 0);
        push_start(2, 0, 0, 0);
        le_q.push_back(4'd0);
        le_q.push_back(4'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        wait_cond(1, 29, "restart_row1");
        enable = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("final_start_count", start_count, 32);
        chk("final_le_count", le_count, 29);
        chk("final_start_queue", start_q.size(), 0);
        chk("final_le_queue", le_q.size(), 0);
        chk("final_blank", int'(blank_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
